// File: rtl/buffer_uart_sender.sv
// Pops variable-length elements from the send buffer and serializes them as 8N1 UART bytes,
// most significant byte first. All outputs are registered.
module buffer_uart_sender #(
  parameter int unsigned MAX_BITS_TO_SEND = 128,
  parameter int unsigned CLKS_PER_BIT     = 868
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      buffer_not_empty,
  input  logic [MAX_BITS_TO_SEND-1:0]               top_data_to_send,
  input  logic [$clog2(MAX_BITS_TO_SEND+1)-1:0]     top_number_of_bits_to_send,
  output logic                                      pop_element,
  output logic                                      tx,
  output logic                                      busy
);

  localparam int unsigned CntW     = $clog2(MAX_BITS_TO_SEND + 1);
  localparam int unsigned NumBytes = MAX_BITS_TO_SEND / 8;
  localparam int unsigned NbW      = $clog2(NumBytes + 1);
  localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  MaxBits  = CntW'(MAX_BITS_TO_SEND);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                      state_q, state_d;
  logic                        tx_q, tx_d;
  logic                        pop_q, pop_d;
  logic                        busy_q, busy_d;
  logic [1:0]                  settle_q, settle_d;
  logic [BaudW-1:0]            baud_q, baud_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [NbW-1:0]              byte_idx_q, byte_idx_d;
  logic [MAX_BITS_TO_SEND-1:0] data_q, data_d;

  logic [CntW-1:0] n_clamped;
  logic [CntW:0]   n_round;
  logic [NbW-1:0]  nb_sample;
  logic [7:0]      cur_byte;

  always_comb begin
    n_clamped = (top_number_of_bits_to_send > MaxBits) ? MaxBits : top_number_of_bits_to_send;
    n_round   = {1'b0, n_clamped} + (CntW + 1)'(7);
    nb_sample = NbW'(n_round >> 3);
  end

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NumBytes; k++) begin
      if (byte_idx_q == NbW'(k)) begin
        cur_byte = data_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    pop_d      = 1'b0;
    busy_d     = busy_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    settle_d   = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Settle counter masks the buffer's stale head for two cycles after our own pop.
        if (buffer_not_empty && (settle_q == 2'd0)) begin
          data_d     = top_data_to_send;
          byte_idx_d = nb_sample - NbW'(1);
          pop_d      = 1'b1;
          busy_d     = 1'b1;
          settle_d   = 2'd2;
          if (nb_sample != '0) begin
            state_d = StStart;
            tx_d    = 1'b0;
            baud_d  = '0;
          end
        end
      end
      StStart: begin
        if (baud_q == BaudLast) begin
          state_d   = StData;
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (byte_idx_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q - NbW'(1);
            state_d    = StStart;
            tx_d       = 1'b0;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      settle_q   <= 2'd0;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      settle_q   <= settle_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
    end
  end

  assign pop_element = pop_q;
  assign tx          = tx_q;
  assign busy        = busy_q;

endmodule

// File: doc/buffer_uart_sender.md
# buffer_uart_sender

Downstream consumer of the send buffer. It takes the element at the head of the buffer (variable-length, right-aligned data plus a bit count), pops it, and serializes it onto a UART TX line as 8N1 bytes, most significant byte first. It sits between the send buffer and the board UART pin, and respects the buffer's two-cycle output-valid latency after a pop.

## Interface
- `MAX_BITS_TO_SEND`, 128: width of the data word. Must be a multiple of 8.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200 baud). Must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `buffer_not_empty`  in  1  the buffer's head element is valid.
- `top_data_to_send`  in  MAX_BITS_TO_SEND  head data, right-aligned.
- `top_number_of_bits_to_send`  in  $clog2(MAX_BITS_TO_SEND+1)  count of valid low bits in the head data.
- `pop_element`  out  1  one-cycle pulse that removes the head element.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high from element latch until the last stop bit ends.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - Sample the inputs only when `buffer_not_empty`=1 and the settle counter is 0.
  - On a valid sample:
    - latch the data and `n`, where `n` = min(`top_number_of_bits_to_send`, `MAX_BITS_TO_SEND`);
    - set byte count `nb` = (n+7)>>3, using $clog2(MAX_BITS_TO_SEND/8+1) bits;
    - pulse `pop_element` and load the settle counter with 2;
    - go to START if `nb`>0, otherwise stay in IDLE.
- **Byte order**
  - Bytes are sent at index `nb`-1 down to 0, where byte k = data[8k+7:8k].
  - Bits above `n` in the top byte are sent as they are latched. Upstream guarantees they are zero.
- **START**: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA**: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
- **STOP**: `tx`=1 for CLKS_PER_BIT cycles, then:
  - decrement the byte index;
  - if bytes remain, go to START with no idle gap;
  - otherwise go to IDLE.
- **Settle counter**
  - Decrements each cycle while nonzero, in any state.
  - It guarantees that IDLE never acts on stale buffer outputs after its own pop.
- **Counters**
  - Baud counter: $clog2(CLKS_PER_BIT) bits, reset to 0 on every state entry.
  - Bit index: 3 bits.
- **Reset**: `tx`=1, `pop_element`=0, `busy`=0, FSM=IDLE, settle counter=0.
  - Reset mid-frame abandons the frame. `tx` is high the cycle after reset is sampled.
  - An already-popped element is lost.

## Timing
- **Pop timing**
  - The valid sample occurs in cycle t.
  - `pop_element`=1 in cycle t+1 only.
  - `busy`=1 from cycle t+1.
- **Start of frame**: `tx` falls in cycle t+1. Start bit spans cycles t+1 .. t+CLKS_PER_BIT.
- **Frame length**
  - Each byte takes exactly 10·CLKS_PER_BIT cycles.
  - An element takes `nb`·10·CLKS_PER_BIT cycles.
- **End of element**
  - The last stop bit ends at cycle t+nb·10·CLKS_PER_BIT.
  - IDLE (`busy`=0) follows in the next cycle.
- **Next sample**
  - The earliest next sample is 2 cycles after the pop cycle. For `n`=0 elements this is cycle t+3.
  - `busy` is high only during cycle t+1 for an `n`=0 element.
- **Registered outputs**: all outputs are registered, with no combinational path from inputs to outputs.
- **No double pop**: a second pop is never issued while `buffer_not_empty` is still high from the previous element's stale value.

## Test plan
- **Single byte**
  - Stimulus: CLKS_PER_BIT=4; head 0x41, `n`=8, `buffer_not_empty`=1.
  - Required: one `pop_element` pulse, then `tx` sequence 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, then `busy`=0.
- **Partial byte**
  - Stimulus: head 0xABC, `n`=12.
  - Required: `nb`=2; bytes 0x0A then 0xBC, back-to-back; 80 cycles total at CLKS_PER_BIT=4.
- **Zero length**
  - Stimulus: head `n`=0.
  - Required: `pop_element` pulses; `tx` stays 1 throughout; a second element is sampled no earlier than 2 cycles after the pop.
- **Full width and clamp**
  - Stimulus: `n`=128 with all-ones data → 16 bytes of 0xFF, one pop.
  - Stimulus: `n`=129 (value is representable) → clamped, same 16 bytes.
- **Back-to-back elements**
  - Stimulus: buffer model with two queued elements and 2-cycle output latency.
  - Required: exactly two pops, in order; no byte duplicated or dropped.
- **Reset mid-operation**
  - Stimulus: assert `reset` during a DATA bit.
  - Required: next cycle `tx`=1, `busy`=0, `pop_element`=0; the next element then transmits cleanly.
